imm_extend_pipe: RTL and testbench

//  Parametrised, pipelined successor to the decode-stage immediate extender.

---
 rtl/imm_extend_pipe.sv | 189 ++++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe
//  Description : Pipelined immediate extender. It sits between decode and
//                execute and supports the ARM rotated-immediate and
//                split-halfword forms. It also produces the shifter carry-out
//                and flags reserved extension modes. The datapath is an
//                elastic valid/ready pipeline of 1 or 2 register stages, with
//                flush support for branch redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           Instr,
    input  logic [2:0]            ImmSrc,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ExtImm,
    output logic                  imm_carry,
    output logic                  imm_carry_valid,
    output logic                  imm_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam logic [2:0] c_MODE_ZX8    = 3'b000;
    localparam logic [2:0] c_MODE_ZX12   = 3'b001;
    localparam logic [2:0] c_MODE_BRANCH = 3'b010;
    localparam logic [2:0] c_MODE_ROT    = 3'b011;
    localparam logic [2:0] c_MODE_HALF   = 3'b100;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] ext;
        logic                  carry;
        logic                  carry_valid;
        logic                  illegal;
        logic [TAG_WIDTH-1:0]  tag;
    } payload_t;

    logic [31:0] w_rot_src;
    logic [5:0]  w_rot_amt;
    logic [31:0] w_rot_val;
    logic        w_rot_nonzero;
    payload_t    w_new;

    // 32-bit rotate-right of the 8-bit immediate by twice the rotate field.
    // A shift by 32 gives zero, so a rotate amount of 0 returns the source unchanged.
    always_comb begin
        w_rot_src     = {24'b0, Instr[7:0]};
        w_rot_amt     = {1'b0, Instr[11:8], 1'b0};
        w_rot_val     = (w_rot_src >> w_rot_amt) | (w_rot_src << (6'd32 - w_rot_amt));
        w_rot_nonzero = (Instr[11:8] != 4'd0);
    end

    // Decode the extension mode into the payload that enters the first stage.
    always_comb begin
        w_new     = '0;
        w_new.tag = in_tag;
        case (ImmSrc)
            c_MODE_ZX8:    w_new.ext[7:0]  = Instr[7:0];
            c_MODE_ZX12:   w_new.ext[11:0] = Instr[11:0];
            c_MODE_BRANCH: begin
                w_new.ext       = {DATA_WIDTH{Instr[23]}};
                w_new.ext[25:0] = {Instr, 2'b00};
            end
            c_MODE_ROT: begin
                w_new.ext[31:0]    = w_rot_val;
                w_new.carry_valid  = w_rot_nonzero;
                w_new.carry        = w_rot_nonzero & w_rot_val[31];
            end
            c_MODE_HALF:   w_new.ext[7:0]  = {Instr[11:8], Instr[3:0]};
            default:       w_new.illegal   = 1'b1;
        endcase
    end

    generate
        if (PIPE_DEPTH == 1) begin : g_depth1
            logic     s1_valid_q, s1_valid_d;
            payload_t s1_pay_q,   s1_pay_d;
            logic     w_s1_load;

            // The single stage loads when it is empty or the consumer takes its beat.
            always_comb begin
                w_s1_load  = !s1_valid_q | out_ready;
                s1_valid_d = s1_valid_q;
                s1_pay_d   = s1_pay_q;
                if (w_s1_load) begin
                    s1_valid_d = in_valid;
                    if (in_valid) begin
                        s1_pay_d = w_new;
                    end
                end
                if (flush) begin
                    s1_valid_d = 1'b0;
                end
            end

            // Stage register; reset also clears the visible payload.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid_q <= 1'b0;
                    s1_pay_q   <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_pay_q   <= s1_pay_d;
                end
            end

            assign in_ready        = flush | w_s1_load;
            assign out_valid       = s1_valid_q;
            assign ExtImm          = s1_pay_q.ext;
            assign imm_carry       = s1_pay_q.carry;
            assign imm_carry_valid = s1_pay_q.carry_valid;
            assign imm_illegal     = s1_pay_q.illegal;
            assign out_tag         = s1_pay_q.tag;
        end else begin : g_depth2
            logic     s1_valid_q, s1_valid_d;
            logic     s2_valid_q, s2_valid_d;
            payload_t s1_pay_q,   s1_pay_d;
            payload_t s2_pay_q,   s2_pay_d;
            logic     w_s2_load;
            logic     w_s1_adv;
            logic     w_s1_load;

            // Each stage loads when it is empty or its downstream takes the beat.
            // in_ready therefore depends combinationally on out_ready.
            always_comb begin
                w_s2_load  = !s2_valid_q | out_ready;
                w_s1_adv   = s1_valid_q & w_s2_load;
                w_s1_load  = !s1_valid_q | w_s1_adv;

                s1_valid_d = s1_valid_q;
                s1_pay_d   = s1_pay_q;
                s2_valid_d = s2_valid_q;
                s2_pay_d   = s2_pay_q;

                if (w_s1_load) begin
                    s1_valid_d = in_valid;
                    if (in_valid) begin
                        s1_pay_d = w_new;
                    end
                end
                if (w_s2_load) begin
                    s2_valid_d = s1_valid_q;
                    if (s1_valid_q) begin
                        s2_pay_d = s1_pay_q;
                    end
                end
                if (flush) begin
                    s1_valid_d = 1'b0;
                    s2_valid_d = 1'b0;
                end
            end

            // Stage registers; reset also clears the visible payload.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid_q <= 1'b0;
                    s2_valid_q <= 1'b0;
                    s1_pay_q   <= '0;
                    s2_pay_q   <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s2_valid_q <= s2_valid_d;
                    s1_pay_q   <= s1_pay_d;
                    s2_pay_q   <= s2_pay_d;
                end
            end

            assign in_ready        = flush | w_s1_load;
            assign out_valid       = s2_valid_q;
            assign ExtImm          = s2_pay_q.ext;
            assign imm_carry       = s2_pay_q.carry;
            assign imm_carry_valid = s2_pay_q.carry_valid;
            assign imm_illegal     = s2_pay_q.illegal;
            assign out_tag         = s2_pay_q.tag;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_extend_pipe
//  Description : Directed self-checking bench for imm_extend_pipe. It drives
//                a 32-bit, 2-stage instance and a 64-bit, 1-stage instance
//                from the same input stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] Instr;
    logic [2:0]  ImmSrc;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ExtImm;
    logic        imm_carry;
    logic        imm_carry_valid;
    logic        imm_illegal;
    logic [4:0]  out_tag;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] ext64;
    logic        carry64;
    logic        cv64;
    logic        ill64;
    logic [4:0]  tag64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_WIDTH(32), .PIPE_DEPTH(2), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ExtImm(ExtImm), .imm_carry(imm_carry), .imm_carry_valid(imm_carry_valid),
        .imm_illegal(imm_illegal), .out_tag(out_tag)
    );

    imm_extend_pipe #(.DATA_WIDTH(64), .PIPE_DEPTH(1), .TAG_WIDTH(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .ExtImm(ext64), .imm_carry(carry64), .imm_carry_valid(cv64),
        .imm_illegal(ill64), .out_tag(tag64)
    );

    typedef struct {
        logic [23:0] instr;
        logic [2:0]  src;
        logic [31:0] ext;
        logic        c;
        logic        cv;
        logic        ill;
    } vec_t;

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Instr = '0; ImmSrc = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, ExtImm, imm_carry, imm_carry_valid, imm_illegal, out_tag} !== 41'd0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b ext=%h c=%b cv=%b ill=%b tag=%h, want all 0",
                     out_valid, ExtImm, imm_carry, imm_carry_valid, imm_illegal, out_tag);
        end
        total++;
        if ({out_valid64, ext64} !== 65'd0) begin
            bad++;
            $display("FAIL reset_state64: got valid=%b ext=%h, want 0", out_valid64, ext64);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; ImmSrc = 3'b010; Instr = 24'hFFFFFE; in_tag = 5'd1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL latency_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL latency_early: out_valid=%b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || ExtImm !== 32'hFFFFFFF8 || out_tag !== 5'd1) begin
            bad++;
            $display("FAIL latency_result: valid=%b ext=%h tag=%h, want 1 FFFFFFF8 01", out_valid, ExtImm, out_tag);
        end
    endtask

    task automatic test_modes();
        vec_t v[12];
        v[0]  = '{24'h123456, 3'b000, 32'h00000056, 1'b0, 1'b0, 1'b0};
        v[1]  = '{24'h123456, 3'b001, 32'h00000456, 1'b0, 1'b0, 1'b0};
        v[2]  = '{24'h000001, 3'b010, 32'h00000004, 1'b0, 1'b0, 1'b0};
        v[3]  = '{24'h8000FF, 3'b010, 32'hFE0003FC, 1'b0, 1'b0, 1'b0};
        v[4]  = '{24'h0004FF, 3'b011, 32'hFF000000, 1'b1, 1'b1, 1'b0};
        v[5]  = '{24'h0000A5, 3'b011, 32'h000000A5, 1'b0, 1'b0, 1'b0};
        v[6]  = '{24'h000240, 3'b011, 32'h00000004, 1'b0, 1'b1, 1'b0};
        v[7]  = '{24'h000F03, 3'b011, 32'h0000000C, 1'b0, 1'b1, 1'b0};
        v[8]  = '{24'h000A0B, 3'b100, 32'h000000AB, 1'b0, 1'b0, 1'b0};
        v[9]  = '{24'hFFFFFF, 3'b110, 32'h00000000, 1'b0, 1'b0, 1'b1};
        v[10] = '{24'h0004FF, 3'b101, 32'h00000000, 1'b0, 1'b0, 1'b1};
        v[11] = '{24'h0004FF, 3'b111, 32'h00000000, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; Instr = v[i].instr; ImmSrc = v[i].src; in_tag = 5'(i + 2);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || ExtImm !== v[i].ext || imm_carry !== v[i].c ||
                imm_carry_valid !== v[i].cv || imm_illegal !== v[i].ill || out_tag !== 5'(i + 2)) begin
                bad++;
                $display("FAIL mode_vec%0d: got v=%b ext=%h c=%b cv=%b ill=%b tag=%h, want 1 %h %b %b %b %h",
                         i, out_valid, ExtImm, imm_carry, imm_carry_valid, imm_illegal, out_tag,
                         v[i].ext, v[i].c, v[i].cv, v[i].ill, 5'(i + 2));
            end
        end
    endtask

    task automatic test_stall();
        int          exp_tag   = 1;
        int          next_tag  = 1;
        bit          saw_full  = 1'b0;
        bit          stall_prev = 1'b0;
        logic [31:0] prev_ext  = '0;
        logic [4:0]  prev_tag  = '0;
        for (int c = 0; c < 40 && exp_tag <= 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (next_tag <= 8);
            ImmSrc    = 3'b000;
            Instr     = 24'(next_tag * 3);
            in_tag    = 5'(next_tag);
            #1;
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || ExtImm !== prev_ext || out_tag !== prev_tag) begin
                    bad++;
                    $display("FAIL stall_hold c%0d: v=%b ext=%h tag=%h, want 1 %h %h",
                             c, out_valid, ExtImm, out_tag, prev_ext, prev_tag);
                end
            end
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) next_tag++;
            if (out_valid && out_ready) begin
                total++;
                if (out_tag !== 5'(exp_tag) || ExtImm !== 32'(exp_tag * 3)) begin
                    bad++;
                    $display("FAIL stall_order: tag=%0d ext=%h, want tag=%0d ext=%h",
                             out_tag, ExtImm, exp_tag, 32'(exp_tag * 3));
                end
                exp_tag++;
            end
            stall_prev = out_valid && !out_ready;
            prev_ext   = ExtImm;
            prev_tag   = out_tag;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (exp_tag != 9) begin
            bad++; $display("FAIL stall_count: delivered %0d beats, want 8", exp_tag - 1);
        end
        total++;
        if (!saw_full) begin
            bad++; $display("FAIL stall_in_ready: in_ready never fell (got 1), want 0 while full");
        end
    endtask

    task automatic test_flush();
        bit got = 1'b0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; ImmSrc = 3'b000; Instr = 24'd20; in_tag = 5'd20;
        @(negedge clk);
        Instr = 24'd21; in_tag = 5'd21;
        @(negedge clk);
        Instr = 24'd22; in_tag = 5'd22;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_full: in_ready=%b, want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_in_ready: in_ready=%b during flush, want 1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_clear: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1; in_valid = 1'b1; Instr = 24'd23; in_tag = 5'd23;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                total++;
                if (out_tag !== 5'd23 || ExtImm !== 32'd23) begin
                    bad++;
                    $display("FAIL flush_first: tag=%0d ext=%h, want tag=23 ext=00000017", out_tag, ExtImm);
                end
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL flush_timeout: out_valid=0 after 10 cycles, want 1");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; ImmSrc = 3'b011; Instr = 24'h0004FF; in_tag = 5'd9;
        @(negedge clk);
        in_tag = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_tag !== 5'd9 || imm_carry !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: v=%b tag=%0d c=%b, want 1 9 1", out_valid, out_tag, imm_carry);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({out_valid, ExtImm, imm_carry, imm_carry_valid, imm_illegal, out_tag} !== 41'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: v=%b ext=%h c=%b cv=%b ill=%b tag=%h, want all 0",
                     out_valid, ExtImm, imm_carry, imm_carry_valid, imm_illegal, out_tag);
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_mid_drop: out_valid=%b after reset, want 0", out_valid);
            end
        end
    endtask

    task automatic test_wide();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; ImmSrc = 3'b010; Instr = 24'h800000; in_tag = 5'd3;
        #1;
        total++;
        if (in_ready64 !== 1'b1) begin
            bad++; $display("FAIL wide_in_ready: got %b want 1", in_ready64);
        end
        @(negedge clk);
        ImmSrc = 3'b011; Instr = 24'h0004FF; in_tag = 5'd4;
        total++;
        if (out_valid64 !== 1'b1 || ext64 !== 64'hFFFFFFFFFE000000 || tag64 !== 5'd3) begin
            bad++;
            $display("FAIL wide_branch: v=%b ext=%h tag=%0d, want 1 FFFFFFFFFE000000 3", out_valid64, ext64, tag64);
        end
        @(negedge clk);
        ImmSrc = 3'b111; Instr = 24'hFFFFFF; in_tag = 5'd5;
        total++;
        if (out_valid64 !== 1'b1 || ext64 !== 64'h00000000FF000000 || carry64 !== 1'b1 ||
            cv64 !== 1'b1 || ill64 !== 1'b0 || tag64 !== 5'd4) begin
            bad++;
            $display("FAIL wide_rot: v=%b ext=%h c=%b cv=%b ill=%b tag=%0d, want 1 00000000FF000000 1 1 0 4",
                     out_valid64, ext64, carry64, cv64, ill64, tag64);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid64 !== 1'b1 || ext64 !== 64'd0 || ill64 !== 1'b1 || cv64 !== 1'b0 || tag64 !== 5'd5) begin
            bad++;
            $display("FAIL wide_illegal: v=%b ext=%h ill=%b cv=%b tag=%0d, want 1 0 1 0 5",
                     out_valid64, ext64, ill64, cv64, tag64);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_modes();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
